// File: rtl/bce_pipe_if.sv
// Request/result bundle between the execute stage and the branch-condition unit.
interface bce_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       bf;
  logic             pred_taken;
  logic [TAG_W-1:0] tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic             is_branch;
  logic             mispredict;
  logic [TAG_W-1:0] out_tag;
  logic             clr_cnt;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mis_cnt;

  modport master (
    output in_valid, a, b, bf, pred_taken, tag, flush, out_ready, clr_cnt,
    input  in_ready, out_valid, taken, is_branch, mispredict, out_tag, br_cnt, mis_cnt
  );
  modport slave (
    input  in_valid, a, b, bf, pred_taken, tag, flush, out_ready, clr_cnt,
    output in_ready, out_valid, taken, is_branch, mispredict, out_tag, br_cnt, mis_cnt
  );
endinterface

// File: rtl/bce_pipe.sv
// Pipelined branch-condition evaluator: one-entry result register with
// mispredict flagging and saturating branch/mispredict statistics.
module bce_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  bce_pipe_if.slave   bus
);
  logic             valid_q, valid_d;
  logic             taken_q, taken_d;
  logic             br_q, br_d;
  logic             mis_q, mis_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  logic s, z, cond, is_br, in_ready, accept, xfer;

  assign s = bus.a[WIDTH-1];
  assign z = (bus.a == '0);

  always_comb begin
    cond  = 1'b0;
    is_br = 1'b1;
    unique casez (bus.bf)
      4'b0010: cond = s;
      4'b0011: cond = ~s;
      4'b100?: cond = (bus.a == bus.b);
      4'b101?: cond = (bus.a != bus.b);
      4'b110?: cond = s | z;
      4'b111?: cond = ~s & ~z;
      default: is_br = 1'b0;
    endcase
  end

  assign in_ready = ~valid_q | bus.out_ready;
  assign accept   = bus.in_valid & in_ready & ~bus.flush;
  assign xfer     = valid_q & bus.out_ready;

  always_comb begin
    valid_d   = valid_q;
    taken_d   = taken_q;
    br_d      = br_q;
    mis_d     = mis_q;
    tag_d     = tag_q;
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (accept) begin
      valid_d = 1'b1;
      taken_d = cond;
      br_d    = is_br;
      mis_d   = is_br & (cond != bus.pred_taken);
      tag_d   = bus.tag;
    end else if (xfer || bus.flush) begin
      valid_d = 1'b0;
    end
    // A transfer in a flush cycle has already left the unit, so it still counts.
    if (bus.clr_cnt) begin
      br_cnt_d  = '0;
      mis_cnt_d = '0;
    end else if (xfer && br_q) begin
      if (br_cnt_q != '1) br_cnt_d = br_cnt_q + CNT_W'(1);
      if (mis_q && mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      taken_q   <= 1'b0;
      br_q      <= 1'b0;
      mis_q     <= 1'b0;
      tag_q     <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      taken_q   <= taken_d;
      br_q      <= br_d;
      mis_q     <= mis_d;
      tag_q     <= tag_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = valid_q;
  assign bus.taken      = taken_q;
  assign bus.is_branch  = br_q;
  assign bus.mispredict = mis_q;
  assign bus.out_tag    = tag_q;
  assign bus.br_cnt     = br_cnt_q;
  assign bus.mis_cnt    = mis_cnt_q;
endmodule

// File: tb/tb_bce_pipe.sv
// Bench for bce_pipe: a 16-bit-counter and a 2-bit-counter instance share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_bce_pipe;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  bce_pipe_if #(.WIDTH(32), .TAG_W(6), .CNT_W(16)) bus16 ();
  bce_pipe_if #(.WIDTH(32), .TAG_W(6), .CNT_W(2))  bus2 ();

  assign bus2.in_valid   = bus16.in_valid;
  assign bus2.a          = bus16.a;
  assign bus2.b          = bus16.b;
  assign bus2.bf         = bus16.bf;
  assign bus2.pred_taken = bus16.pred_taken;
  assign bus2.tag        = bus16.tag;
  assign bus2.flush      = bus16.flush;
  assign bus2.out_ready  = bus16.out_ready;
  assign bus2.clr_cnt    = bus16.clr_cnt;

  bce_pipe #(.WIDTH(32), .TAG_W(6), .CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  bce_pipe #(.WIDTH(32), .TAG_W(6), .CNT_W(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Branch rules in signed-arithmetic form: returns {is_branch, taken}.
  function automatic logic [1:0] rule(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa;
    sa = $signed(a);
    case (f)
      4'd2:         return {1'b1, sa < 0};
      4'd3:         return {1'b1, sa >= 0};
      4'd8, 4'd9:   return {1'b1, a == b};
      4'd10, 4'd11: return {1'b1, a != b};
      4'd12, 4'd13: return {1'b1, sa <= 0};
      4'd14, 4'd15: return {1'b1, sa > 0};
      default:      return 2'b00;
    endcase
  endfunction

  // Model state: the result slot and unbounded-then-capped counters.
  bit       m_v, m_t, m_b, m_m;
  bit [5:0] m_tag;
  int       m_br16, m_mis16, m_br2, m_mis2;

  initial begin
    bit       n_v, n_t, n_b, n_m, xf, acc;
    bit [5:0] n_tag;
    int       n_br16, n_mis16, n_br2, n_mis2;
    logic [1:0] r;
    {m_v, m_t, m_b, m_m, m_tag} = '0;
    {m_br16, m_mis16, m_br2, m_mis2} = '0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("out_valid16", bus16.out_valid, m_v);
        chk("in_ready16", bus16.in_ready, !m_v || bus16.out_ready);
        chk("taken16", bus16.taken, m_t);
        chk("is_branch16", bus16.is_branch, m_b);
        chk("mispredict16", bus16.mispredict, m_m);
        chk("out_tag16", bus16.out_tag, m_tag);
        chk("br_cnt16", bus16.br_cnt, m_br16);
        chk("mis_cnt16", bus16.mis_cnt, m_mis16);
        chk("out_valid2", bus2.out_valid, m_v);
        chk("out_tag2", bus2.out_tag, m_tag);
        chk("br_cnt2", bus2.br_cnt, m_br2);
        chk("mis_cnt2", bus2.mis_cnt, m_mis2);
      end
      xf  = m_v && bus16.out_ready;
      acc = bus16.in_valid && (!m_v || bus16.out_ready) && !bus16.flush;
      {n_v, n_t, n_b, n_m, n_tag} = {m_v, m_t, m_b, m_m, m_tag};
      {n_br16, n_mis16, n_br2, n_mis2} = {m_br16, m_mis16, m_br2, m_mis2};
      if (acc) begin
        r = rule(bus16.bf, bus16.a, bus16.b);
        n_v = 1; n_b = r[1]; n_t = r[0];
        n_m = r[1] && (r[0] != bus16.pred_taken);
        n_tag = bus16.tag;
      end else if (xf || bus16.flush) n_v = 0;
      if (bus16.clr_cnt) {n_br16, n_mis16, n_br2, n_mis2} = '0;
      else if (xf && m_b) begin
        n_br16 = (m_br16 < 65535) ? m_br16 + 1 : m_br16;
        n_br2  = (m_br2 < 3) ? m_br2 + 1 : m_br2;
        if (m_m) begin
          n_mis16 = (m_mis16 < 65535) ? m_mis16 + 1 : m_mis16;
          n_mis2  = (m_mis2 < 3) ? m_mis2 + 1 : m_mis2;
        end
      end
      @(posedge clk);
      if (rst) begin
        {m_v, m_t, m_b, m_m, m_tag} = '0;
        {m_br16, m_mis16, m_br2, m_mis2} = '0;
      end else begin
        {m_v, m_t, m_b, m_m, m_tag} = {n_v, n_t, n_b, n_m, n_tag};
        {m_br16, m_mis16, m_br2, m_mis2} = {n_br16, n_mis16, n_br2, n_mis2};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] f, input logic [31:0] av, input logic [31:0] bv,
                     input logic p, input logic [5:0] t);
    bus16.in_valid = 1'b1; bus16.bf = f; bus16.a = av; bus16.b = bv;
    bus16.pred_taken = p; bus16.tag = t;
  endtask

  initial begin
    int br_snap;
    rst = 1'b1;
    bus16.in_valid = 0; bus16.a = 0; bus16.b = 0; bus16.bf = 0; bus16.pred_taken = 0;
    bus16.tag = 0; bus16.flush = 0; bus16.out_ready = 1; bus16.clr_cnt = 0;
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;
    step();
    chk("rst_out_valid", bus16.out_valid, 0);
    chk("rst_in_ready", bus16.in_ready, 1);
    chk("rst_br_cnt", bus16.br_cnt, 0);
    chk("rst_mis_cnt", bus16.mis_cnt, 0);

    // Four back-to-back requests.
    req(4'b0010, 32'h8000_0000, 0, 0, 6'd1); step();
    chk("r1_valid", bus16.out_valid, 1); chk("r1_taken", bus16.taken, 1);
    chk("r1_mis", bus16.mispredict, 1); chk("r1_tag", bus16.out_tag, 1);
    req(4'b1000, 5, 5, 1, 6'd2); step();
    chk("r2_taken", bus16.taken, 1); chk("r2_mis", bus16.mispredict, 0);
    req(4'b1100, 0, 0, 0, 6'd3); step();
    chk("r3_taken", bus16.taken, 1); chk("r3_mis", bus16.mispredict, 1);
    req(4'b1110, 0, 0, 0, 6'd4); step();
    chk("r4_taken", bus16.taken, 0); chk("r4_mis", bus16.mispredict, 0);
    bus16.in_valid = 0; step();
    chk("b2b_br_cnt", bus16.br_cnt, 4); chk("b2b_mis_cnt", bus16.mis_cnt, 2);
    chk("b2b_br_cnt_sat2", bus2.br_cnt, 3);

    // Backpressure: hold A, offer B.
    bus16.out_ready = 0;
    req(4'b1010, 1, 2, 1, 6'd10); step();
    req(4'b0011, 1, 0, 0, 6'd11);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_in_ready", bus16.in_ready, 0);
      chk("bp_tag", bus16.out_tag, 10);
      chk("bp_taken", bus16.taken, 1);
    end
    bus16.out_ready = 1; step();
    chk("bp_next_tag", bus16.out_tag, 11); chk("bp_next_mis", bus16.mispredict, 1);
    bus16.in_valid = 0; step();
    chk("bp_br_cnt", bus16.br_cnt, 6); chk("bp_mis_cnt", bus16.mis_cnt, 3);

    // Non-branch code.
    req(4'b0101, 0, 0, 1, 6'd20); step();
    chk("nb_valid", bus16.out_valid, 1); chk("nb_isbr", bus16.is_branch, 0);
    chk("nb_taken", bus16.taken, 0); chk("nb_mis", bus16.mispredict, 0);
    bus16.in_valid = 0; step();
    chk("nb_br_cnt", bus16.br_cnt, 6);

    // Flush with a held entry and a new request.
    bus16.out_ready = 0;
    req(4'b0010, 32'hFFFF_FFFF, 0, 0, 6'd30); step();
    req(4'b1000, 7, 7, 0, 6'd31); bus16.flush = 1; step();
    chk("fl_valid", bus16.out_valid, 0);
    bus16.flush = 0; bus16.in_valid = 0; bus16.out_ready = 1; step();
    chk("fl_br_cnt", bus16.br_cnt, 6); chk("fl_mis_cnt", bus16.mis_cnt, 3);

    // Saturation on the 2-bit instance, then clear racing a transfer.
    bus16.clr_cnt = 1; step(); bus16.clr_cnt = 0;
    chk("clr_br2", bus2.br_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      req(4'b1010, i, 100, 0, 6'(40 + i)); step();
    end
    bus16.in_valid = 0; step();
    chk("sat_br2", bus2.br_cnt, 3); chk("sat_mis2", bus2.mis_cnt, 3);
    chk("sat_br16", bus16.br_cnt, 5);
    req(4'b1000, 1, 1, 0, 6'd50); step();
    bus16.in_valid = 0; bus16.clr_cnt = 1; step(); bus16.clr_cnt = 0;
    br_snap = bus16.br_cnt;
    chk("clrx_br16", br_snap, 0); chk("clrx_mis16", bus16.mis_cnt, 0);
    chk("clrx_br2", bus2.br_cnt, 0); chk("clrx_valid", bus16.out_valid, 0);
    step(); step();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/bce_pipe.md
Name: bce_pipe

Overview:
Parametrised, pipelined branch-condition evaluation unit. It is the next generation of the combinational branch condition evaluator.
- Evaluates the same branch-function encoding on WIDTH-bit operands.
- Registers the result behind a valid/ready handshake and compares it against the fetch-stage prediction to flag mispredicts.
- Supports a pipeline flush.
- Keeps saturating resolved-branch and mispredict counters for the performance-monitor block.
- Sits between the execute stage and the fetch redirect logic.

Parameters:
WIDTH, 32, operand width in bits (>=2)
TAG_W, 6, width of the instruction tag carried alongside the request
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request this cycle
a  in  WIDTH  first test operand
b  in  WIDTH  second test operand
bf  in  4  branch function code
pred_taken  in  1  fetch-stage prediction for this branch
tag  in  TAG_W  instruction tag
flush  in  1  kill the held entry and any request arriving this cycle
out_valid  out  1  registered result valid
out_ready  in  1  consumer accepts the result
taken  out  1  resolved branch condition
is_branch  out  1  bf was a recognised branch code
mispredict  out  1  is_branch && (taken != pred_taken)
out_tag  out  TAG_W  tag of the held result
clr_cnt  in  1  clear both statistics counters
br_cnt  out  CNT_W  resolved branches, saturating
mis_cnt  out  CNT_W  mispredicts, saturating

Behaviour:
- Reset: on clk edge with rst=1, all state clears:
  - out_valid, taken, is_branch, mispredict, out_tag, br_cnt and mis_cnt all 0.
  - rst overrides flush and clr_cnt.
- Condition decode is combinational on inputs. s = a[WIDTH-1], z = (a == 0).
  - 0010: cond = s
  - 0011: cond = ~s
  - 1000/1001: cond = (a == b)
  - 1010/1011: cond = (a != b)
  - 1100/1101: cond = s | z
  - 1110/1111: cond = ~s & ~z
  - All other codes: cond = 0, is_branch = 0. Listed codes give is_branch = 1.
- Handshake:
  - in_ready = ~out_valid | out_ready (single-entry output register, combinational ready path).
  - Accept = in_valid & in_ready & ~flush.
  - Latency 1: an accepted request appears on the outputs the next cycle with out_valid=1.
- Output register:
  - If accept: load taken, is_branch, mispredict, out_tag; set out_valid = 1.
  - Else if out_valid & out_ready: out_valid <= 0; data fields hold their last values.
  - Outputs stay stable while out_valid=1 and out_ready=0.
- Flush:
  - flush=1 gives out_valid <= 0 next cycle.
  - A request presented in the same cycle is dropped, and is not counted.
  - A transfer (out_valid & out_ready) occurring in the flush cycle still completes and is counted.
- Counters update on each completed transfer with is_branch=1:
  - br_cnt increments by 1.
  - mis_cnt increments by 1 if mispredict=1.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - clr_cnt=1 sets both to 0 and takes priority over a same-cycle increment.
- Back-to-back: with out_ready held 1, the unit sustains one request per cycle; no bubbles.

Test Plan:
- Reset, then idle: out_valid=0, in_ready=1, br_cnt=mis_cnt=0.
- WIDTH=32, out_ready=1, four requests in consecutive cycles:
  - bf=0010, a=0x8000_0000, pred=0 -> taken=1, mispredict=1.
  - bf=1000, a=b=5, pred=1 -> taken=1, mispredict=0.
  - bf=1100, a=0, pred=0 -> taken=1, mispredict=1.
  - bf=1110, a=0, pred=0 -> taken=0, mispredict=0.
  - Each result appears 1 cycle after its request. Final br_cnt=4, mis_cnt=2.
- Backpressure:
  - out_ready=0 with result held: in_ready=0, outputs stable for 5 cycles, no new acceptance.
  - out_ready=1: transfer completes, and a new request is accepted the same cycle.
- Non-branch code: bf=0101, a=0, pred=1 -> out_valid=1, is_branch=0, taken=0, mispredict=0; counters unchanged.
- Flush: held result plus new request with flush=1 and out_ready=0 -> next cycle out_valid=0; neither entry counted.
- Saturation and clear, CNT_W=2:
  - 5 mispredicting branches -> br_cnt=3, mis_cnt=3.
  - clr_cnt=1 in the same cycle as a transfer -> both counters 0.
